// File: rtl/rng_pattern_sequencer.sv
// Round controller for the memory game. It grows a random symbol pattern, plays it
// on one-hot LEDs, checks the player's entries, and reports win or lose.
module rng_pattern_sequencer #(
  parameter int MAX_LEN       = 16,
  parameter int ON_TICKS      = 4,
  parameter int OFF_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic [1:0] rng_q,
  output logic       rng_enable,
  input  logic       btn_valid,
  input  logic [1:0] btn_code,
  output logic [2:0] led,
  output logic [4:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int AW    = $clog2(MAX_LEN);
  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int MAXT0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAXT  = (MAXT0 > TIMEOUT_TICKS) ? MAXT0 : TIMEOUT_TICKS;
  localparam int CW    = $clog2(MAXT + 1);

  typedef enum logic [2:0] {
    IDLE, GEN_REQ, GEN_CAP, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mem_q [2**AW];
  logic            mem_we;
  logic [1:0]      mem_wdata;
  logic            idx_last;
  logic [1:0]      show_sym;

  logic            rng_enable_q;
  logic [2:0]      led_q;
  logic [4:0]      level_q;
  logic            busy_q, win_q, lose_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = tick ? cnt_q + CW'(1) : cnt_q;
    mem_we    = 1'b0;
    mem_wdata = (rng_q == 2'd3) ? 2'd0 : rng_q;
    idx_last  = (LW'(idx_q) == len_q - LW'(1));
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          len_d   = '0;
          idx_d   = '0;
          state_d = GEN_REQ;
        end
      end
      GEN_REQ: state_d = GEN_CAP;
      GEN_CAP: begin
        mem_we  = 1'b1;
        len_d   = len_q + LW'(1);
        idx_d   = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (tick && cnt_q == CW'(ON_TICKS - 1)) state_d = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (tick && cnt_q == CW'(OFF_TICKS - 1)) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = WAIT_IN;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = SHOW_ON;
          end
        end
      end
      WAIT_IN: begin
        // A button press in the same cycle as the last timeout tick takes priority.
        if (btn_valid) begin
          if (btn_code == mem_q[idx_q]) begin
            if (idx_last) begin
              state_d = (len_q == LW'(MAX_LEN)) ? WIN : GEN_REQ;
            end else begin
              idx_d = idx_q + AW'(1);
              cnt_d = '0;
            end
          end else begin
            state_d = LOSE;
          end
        end else if (tick && cnt_q == CW'(TIMEOUT_TICKS - 1)) begin
          state_d = LOSE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Bypass the memory when the symbol being shown is the one written this cycle.
  assign show_sym = (mem_we && AW'(len_q) == idx_d) ? mem_wdata : mem_q[idx_d];

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[AW'(len_q)] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      rng_enable_q <= 1'b0;
      led_q        <= '0;
      level_q      <= '0;
      busy_q       <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rng_enable_q <= (state_d == GEN_REQ);
      led_q        <= (state_d == SHOW_ON) ? (3'b001 << show_sym) : 3'b000;
      level_q      <= 5'(len_d);
      busy_q       <= !(state_d inside {IDLE, WIN, LOSE});
      win_q        <= (state_d == WIN);
      lose_q       <= (state_d == LOSE);
    end
  end

  assign rng_enable = rng_enable_q;
  assign led        = led_q;
  assign level      = level_q;
  assign busy       = busy_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_rng_pattern_sequencer.sv
// Directed bench for rng_pattern_sequencer: a default instance for the main game
// flow and a MAX_LEN=2 instance for the win path.
module tb_rng_pattern_sequencer;
  localparam int ON_T  = 4;
  localparam int OFF_T = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, start2 = 1'b0, tick = 1'b0, btn_valid = 1'b0;
  logic [1:0] rng_q = 2'd0, btn_code = 2'd0;
  logic       en1, busy1, win1, lose1, en2, busy2, win2, lose2;
  logic [2:0] led1, led2;
  logic [4:0] level1, level2;

  int vectors = 0, miscompares = 0;
  int en1_cnt = 0, en2_cnt = 0;
  logic [2:0] seen [8], hold [8], dark [8];

  rng_pattern_sequencer dut1 (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .rng_q(rng_q),
    .rng_enable(en1), .btn_valid(btn_valid), .btn_code(btn_code), .led(led1),
    .level(level1), .busy(busy1), .win(win1), .lose(lose1));

  rng_pattern_sequencer #(.MAX_LEN(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .tick(tick), .rng_q(rng_q),
    .rng_enable(en2), .btn_valid(btn_valid), .btn_code(btn_code), .led(led2),
    .level(level2), .busy(busy2), .win(win2), .lose(lose2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en1) en1_cnt++;
    if (en2) en2_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick1();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic press(input logic [1:0] code);
    @(negedge clk) begin btn_valid = 1'b1; btn_code = code; end
    @(negedge clk) btn_valid = 1'b0;
  endtask

  task automatic start_game(input bit d2);
    @(negedge clk) if (d2) start2 = 1'b1; else start = 1'b1;
    @(negedge clk) begin start = 1'b0; start2 = 1'b0; end
  endtask

  // Walks playback of n symbols from the first SHOW_ON cycle, recording the LED
  // at entry, just before the last ON tick, and after entering the dark gap.
  task automatic play(input int n, input bit d2);
    for (int s = 0; s < n; s++) begin
      seen[s] = d2 ? led2 : led1;
      repeat (ON_T - 1) tick1();
      hold[s] = d2 ? led2 : led1;
      tick1();
      dark[s] = d2 ? led2 : led1;
      repeat (OFF_T) tick1();
    end
  endtask

  task automatic test_reset();
    int e0;
    cyc(2);
    vectors++; if ({en1, led1, level1, busy1, win1, lose1} !== 13'd0) begin miscompares++; $display("FAIL reset_outputs got %b want 0", {en1, led1, level1, busy1, win1, lose1}); end
    @(negedge clk) reset = 1'b1;
    rng_q = 2'd2;
    start_game(0);
    cyc(2);
    vectors++; if (led1 !== 3'b100) begin miscompares++; $display("FAIL reset_pre_led got %b want 100", led1); end
    tick1();
    #2 reset = 1'b0;
    #1;
    vectors++; if ({led1, busy1, level1} !== 9'd0) begin miscompares++; $display("FAIL reset_async got led=%b busy=%b level=%0d want 0", led1, busy1, level1); end
    @(negedge clk) reset = 1'b1;
    e0 = en1_cnt;
    repeat (6) tick1();
    vectors++; if ({led1, busy1, win1, lose1} !== 6'd0 || en1_cnt != e0) begin miscompares++; $display("FAIL reset_idle got led=%b busy=%b en=%0d want idle", led1, busy1, en1_cnt - e0); end
  endtask

  task automatic test_first_round();
    int e0;
    e0 = en1_cnt;
    rng_q = 2'd2;
    start_game(0);
    vectors++; if (en1 !== 1'b1 || busy1 !== 1'b1) begin miscompares++; $display("FAIL t2_gen_req got en=%b busy=%b want 1 1", en1, busy1); end
    cyc(1);
    vectors++; if (en1 !== 1'b0) begin miscompares++; $display("FAIL t2_en_width got %b want 0", en1); end
    cyc(1);
    vectors++; if (led1 !== 3'b100 || level1 !== 5'd1) begin miscompares++; $display("FAIL t2_show got led=%b level=%0d want 100 1", led1, level1); end
    play(1, 0);
    vectors++; if (hold[0] !== 3'b100 || dark[0] !== 3'b000) begin miscompares++; $display("FAIL t2_timing got hold=%b dark=%b want 100 000", hold[0], dark[0]); end
    repeat (4) tick1();
    vectors++; if (led1 !== 3'b000 || busy1 !== 1'b1 || level1 !== 5'd1 || en1_cnt - e0 != 1) begin miscompares++; $display("FAIL t2_wait_in got led=%b busy=%b level=%0d en=%0d want 000 1 1 1", led1, busy1, level1, en1_cnt - e0); end
  endtask

  task automatic test_grow_pattern();
    int e0;
    logic [2:0] exp3 [3];
    exp3[0] = 3'b100; exp3[1] = 3'b001; exp3[2] = 3'b010;
    e0 = en1_cnt;
    rng_q = 2'd0;
    press(2'd2);
    vectors++; if (en1 !== 1'b1) begin miscompares++; $display("FAIL t3_round2_req got %b want 1", en1); end
    cyc(2);
    play(2, 0);
    for (int s = 0; s < 2; s++) begin
      vectors++; if (seen[s] !== exp3[s] || hold[s] !== exp3[s] || dark[s] !== 3'b000) begin miscompares++; $display("FAIL t3_play2[%0d] got %b/%b/%b want %b", s, seen[s], hold[s], dark[s], exp3[s]); end
    end
    rng_q = 2'd1;
    press(2'd2);
    press(2'd0);
    cyc(2);
    vectors++; if (level1 !== 5'd3 || en1_cnt - e0 != 2) begin miscompares++; $display("FAIL t3_level got level=%0d en=%0d want 3 2", level1, en1_cnt - e0); end
    play(3, 0);
    for (int s = 0; s < 3; s++) begin
      vectors++; if (seen[s] !== exp3[s] || hold[s] !== exp3[s] || dark[s] !== 3'b000) begin miscompares++; $display("FAIL t3_play3[%0d] got %b/%b/%b want %b", s, seen[s], hold[s], dark[s], exp3[s]); end
    end
  endtask

  task automatic test_lose_restart();
    int e0;
    e0 = en1_cnt;
    start_game(0);
    cyc(2);
    vectors++; if (busy1 !== 1'b1 || level1 !== 5'd3 || en1_cnt != e0) begin miscompares++; $display("FAIL t4_start_busy got busy=%b level=%0d en=%0d want 1 3 0", busy1, level1, en1_cnt - e0); end
    press(2'd0);
    vectors++; if (lose1 !== 1'b1 || busy1 !== 1'b0 || level1 !== 5'd3) begin miscompares++; $display("FAIL t4_wrong got lose=%b busy=%b level=%0d want 1 0 3", lose1, busy1, level1); end
    rng_q = 2'd1;
    start_game(0);
    vectors++; if (lose1 !== 1'b0 || busy1 !== 1'b1) begin miscompares++; $display("FAIL t4_restart got lose=%b busy=%b want 0 1", lose1, busy1); end
    cyc(2);
    vectors++; if (level1 !== 5'd1) begin miscompares++; $display("FAIL t4_level got %0d want 1", level1); end
    press(2'd0);
    vectors++; if (lose1 !== 1'b0 || led1 !== 3'b010) begin miscompares++; $display("FAIL t4_btn_drop got lose=%b led=%b want 0 010", lose1, led1); end
    play(1, 0);
    vectors++; if (seen[0] !== 3'b010) begin miscompares++; $display("FAIL t4_play got %b want 010", seen[0]); end
    press(2'd0);
    vectors++; if (lose1 !== 1'b1 || busy1 !== 1'b0 || level1 !== 5'd1) begin miscompares++; $display("FAIL t4_lose got lose=%b busy=%b level=%0d want 1 0 1", lose1, busy1, level1); end
  endtask

  task automatic test_timeout();
    rng_q = 2'd0;
    start_game(0);
    cyc(2);
    play(1, 0);
    repeat (39) tick1();
    vectors++; if (lose1 !== 1'b0 || busy1 !== 1'b1) begin miscompares++; $display("FAIL t5_tick39 got lose=%b busy=%b want 0 1", lose1, busy1); end
    tick1();
    vectors++; if (lose1 !== 1'b1 || busy1 !== 1'b0) begin miscompares++; $display("FAIL t5_timeout got lose=%b busy=%b want 1 0", lose1, busy1); end
    start_game(0);
    cyc(2);
    play(1, 0);
    repeat (39) tick1();
    @(negedge clk) begin tick = 1'b1; btn_valid = 1'b1; btn_code = 2'd0; end
    @(negedge clk) begin tick = 1'b0; btn_valid = 1'b0; end
    vectors++; if (lose1 !== 1'b0 || en1 !== 1'b1) begin miscompares++; $display("FAIL t5_btn_wins got lose=%b en=%b want 0 1", lose1, en1); end
    cyc(2);
    play(2, 0);
    vectors++; if (seen[0] !== 3'b001 || seen[1] !== 3'b001 || level1 !== 5'd2) begin miscompares++; $display("FAIL t5_play got %b %b level=%0d want 001 001 2", seen[0], seen[1], level1); end
    repeat (30) tick1();
    press(2'd0);
    repeat (39) tick1();
    vectors++; if (lose1 !== 1'b0) begin miscompares++; $display("FAIL t5_cnt_clear got lose=%b want 0", lose1); end
    tick1();
    vectors++; if (lose1 !== 1'b1 || level1 !== 5'd2) begin miscompares++; $display("FAIL t5_timeout2 got lose=%b level=%0d want 1 2", lose1, level1); end
  endtask

  task automatic test_win_max_len();
    rng_q = 2'd1;
    start_game(1);
    vectors++; if (en2 !== 1'b1) begin miscompares++; $display("FAIL t6_req got %b want 1", en2); end
    cyc(2);
    play(1, 1);
    press(2'd1);
    rng_q = 2'd2;
    cyc(2);
    vectors++; if (level2 !== 5'd2) begin miscompares++; $display("FAIL t6_level got %0d want 2", level2); end
    play(2, 1);
    vectors++; if (seen[0] !== 3'b010 || seen[1] !== 3'b100) begin miscompares++; $display("FAIL t6_play got %b %b want 010 100", seen[0], seen[1]); end
    start_game(1);
    cyc(2);
    vectors++; if (busy2 !== 1'b1 || level2 !== 5'd2 || en2_cnt != 2) begin miscompares++; $display("FAIL t6_start_busy got busy=%b level=%0d en=%0d want 1 2 2", busy2, level2, en2_cnt); end
    press(2'd1);
    press(2'd2);
    vectors++; if (win2 !== 1'b1 || lose2 !== 1'b0 || busy2 !== 1'b0 || level2 !== 5'd2 || en2 !== 1'b0) begin miscompares++; $display("FAIL t6_win got win=%b lose=%b busy=%b level=%0d en=%b want 1 0 0 2 0", win2, lose2, busy2, level2, en2); end
    rng_q = 2'd0;
    start_game(1);
    vectors++; if (win2 !== 1'b0) begin miscompares++; $display("FAIL t6_win_clear got %b want 0", win2); end
    cyc(2);
    play(1, 1);
    press(2'd3);
    vectors++; if (lose2 !== 1'b1 || win2 !== 1'b0 || level2 !== 5'd1) begin miscompares++; $display("FAIL t6_illegal got lose=%b win=%b level=%0d want 1 0 1", lose2, win2, level2); end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_grow_pattern();
    test_lose_restart();
    test_timeout();
    test_win_max_len();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end
endmodule
